free_list: RTL
==============

# free_list

Physical-register free list for the `WAYS`-wide rename stage. It hands out unused PRF tags to dispatching instructions, which later become PRF write indices. It reclaims each retiring instruction's previous mapping and rolls the speculative head back on a squash. It sits between rename/dispatch and retire, and is the sole source of destination tags for the PRF and map table.

## Interface
- `WAYS`, 4, superscalar width; allocate and free ports per cycle.
- `PRF`, 64, physical register count; tag width is `$clog2(PRF)`.
- `FL_DEPTH`, `PRF`-32, free-list entries; must be a power of two.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `alloc_en`  in  `WAYS`  per-way allocation request from dispatch. Only ways with a nonzero rd set it.
- `alloc_tag`  out  `WAYS` x tag  tag granted to each way. Combinational from current state and `alloc_en`.
- `free_count`  out  `$clog2(FL_DEPTH)+1`  registered count of free tags.
- `ret_en`  in  `WAYS`  per-way retirement of an instruction that allocated a tag.
- `ret_old_tag`  in  `WAYS` x tag  previous mapping of each retiring rd, returned to the list.
- `squash`  in  1  branch mispredict / exception recovery.
- `fl_err`  out  1  sticky over-allocation flag. Tied 0 unless `FREE_LIST_CHECK_EN` is defined.

## Operation
- Storage is a circular array `entries[FL_DEPTH]` with registered pointers `head`, `arch_head` and `tail`, and a count `count`.
- Pointers are `$clog2(FL_DEPTH)` bits and wrap modulo `FL_DEPTH` with no wrap bit; full vs. empty is resolved by `count`.
- Reset:
  - `entries[i] = 32+i`. Architectural x0..x31 map to p0..p31, and p0 is never allocated.
  - `head = arch_head = tail = 0`, `count = FL_DEPTH`, `fl_err = 0`.
- Allocation:
  - Let n_a = popcount(`alloc_en`).
  - Way i receives `entries[head + popcount(alloc_en[i-1:0])]`, so grants are dense and in way order regardless of gaps in `alloc_en`.
  - `alloc_tag[i]` for a way with `alloc_en[i]=0` is `entries[head+popcount(alloc_en[i-1:0])]` and is don't-care to consumers.
  - `head += n_a`.
- Freeing:
  - Let n_r = popcount(`ret_en`).
  - Each `ret_old_tag[i]` with `ret_en[i]` is written at `tail + popcount(ret_en[i-1:0])`.
  - `tail += n_r` and `arch_head += n_r`.
- Count update: `count_next = count - n_a + n_r`.
- Dispatch contract: n_a never exceeds `free_count`. Dispatch stalls when `free_count` is less than the number of rd-writing instructions in its group.
- Squash:
  - `head <= arch_head + n_r`, counting this cycle's retirements. `count <= FL_DEPTH`.
  - Tags allocated speculatively since the last retirement return to the list implicitly; no data is moved.
  - The architectural free count is invariant at `FL_DEPTH`, because each retirement frees one tag and consumes one.
- Simultaneous events:
  - Allocation and free in the same cycle: allocation reads only entries present at the start of the cycle. Freed tags are not bypassed.
  - Squash plus allocation: squash wins and `alloc_en` is ignored for state update.
  - Squash plus retire: retirement is fully applied (tail writes and pointer advance) before the head restore.
- A tag is never present twice; a returned tag is always one not currently in the list.

## Timing
- `alloc_tag` is combinational, valid in the same cycle as `alloc_en`. Dispatch latches it in its rename pipeline register.
- Pointer, count and entry updates are visible the cycle after the request; `free_count` is registered.
- A tag freed in cycle t is allocatable no earlier than cycle t+1.
- Squash in cycle t: `free_count = FL_DEPTH` and the restored `head` take effect in cycle t+1.
- Reset asserted mid-operation: the next edge restores the full reset state regardless of other inputs.

## Configuration
- `FREE_LIST_CHECK_EN` defined:
  - If n_a > `count` in a non-squash cycle, `head` advances by only `count` and `count` becomes 0.
  - `fl_err` sets and holds until reset.
  - A simulation `$error` fires.
- `FREE_LIST_CHECK_EN` undefined: `fl_err` = 0 and over-allocation behaviour is undefined.

## Test plan
- Reset, then `alloc_en`=4'b1111 -> `alloc_tag` = 32,33,34,35; next cycle `free_count` = 28.
- After reset, `alloc_en`=4'b1010 -> way1 = 32, way3 = 33; `free_count` = 30.
- 8 cycles of 4-way allocation -> `free_count` = 0. Then `ret_en`=4'b0011 with old tags 5,7 -> `free_count` = 2 next cycle. A following 2-way allocation yields 5,7 (wrap-around at the tail).
- Allocate 10 tags, retire 3 (old tags 1,2,3), `squash` in the same cycle as the third retirement -> `free_count` = 32. The next 4-way allocation returns 35,36,37,38; the list ends 1,2,3.
- Allocation and free in the same cycle with `count` = 1: alloc 1 + free tag 9 -> granted tag is the old head entry, not 9; `free_count` stays 1.
- With `FREE_LIST_CHECK_EN` and `count` = 2, `alloc_en`=4'b1111 -> `fl_err` = 1 next cycle, `free_count` = 0, and `fl_err` stays 1 until `reset`.

Source files
------------

// File: rtl/free_list_if.sv
// Rename/retire interface of the physical-register free list.
// Dispatch and retire drive the master side; the free list is the slave.
interface free_list_if #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned PRF      = 64,
  parameter int unsigned FL_DEPTH = PRF - 32
);
  localparam int unsigned TAG_W = $clog2(PRF);
  localparam int unsigned CNT_W = $clog2(FL_DEPTH) + 1;

  logic [WAYS-1:0]            alloc_en;
  logic [WAYS-1:0][TAG_W-1:0] alloc_tag;
  logic [CNT_W-1:0]           free_count;
  logic [WAYS-1:0]            ret_en;
  logic [WAYS-1:0][TAG_W-1:0] ret_old_tag;
  logic                       squash;
  logic                       fl_err;

  modport master (
    output alloc_en, ret_en, ret_old_tag, squash,
    input  alloc_tag, free_count, fl_err
  );

  modport slave (
    input  alloc_en, ret_en, ret_old_tag, squash,
    output alloc_tag, free_count, fl_err
  );
endinterface

// File: rtl/free_list.sv
// Circular free list of PRF tags: dense in-order grants, retire reclaim, squash rollback.
// Optional FREE_LIST_CHECK_EN clamps over-allocation and raises sticky fl_err.
module free_list #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned PRF      = 64,
  parameter int unsigned FL_DEPTH = PRF - 32
) (
  input  logic        clock,
  input  logic        reset,
  free_list_if.slave  fl
);
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned TAG_W     = $clog2(PRF);
  localparam int unsigned PTR_W     = $clog2(FL_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  logic [TAG_W-1:0] entries      [FL_DEPTH];
  logic [TAG_W-1:0] entries_next [FL_DEPTH];
  logic [PTR_W-1:0] head, arch_head, tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] alloc_ofs [WAYS];
  logic [CNT_W-1:0] ret_ofs   [WAYS];
  logic [CNT_W-1:0] n_a, n_r, n_grant;

  // Prefix popcounts give each way its dense slot offset.
  always_comb begin
    n_a = '0;
    n_r = '0;
    for (int i = 0; i < WAYS; i++) begin
      alloc_ofs[i] = n_a;
      ret_ofs[i]   = n_r;
      n_a = n_a + CNT_W'(fl.alloc_en[i]);
      n_r = n_r + CNT_W'(fl.ret_en[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      fl.alloc_tag[i] = entries[head + PTR_W'(alloc_ofs[i])];
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic over;
  logic fl_err_q;
  assign over    = !fl.squash && (n_a > count);
  assign n_grant = over ? count : n_a;
  assign fl.fl_err = fl_err_q;
`else
  assign n_grant   = n_a;
  assign fl.fl_err = 1'b0;
`endif

  assign fl.free_count = count;

  // Retired tags land at tail; reset reloads the identity mapping above x0..x31.
  always_comb begin
    entries_next = entries;
    for (int i = 0; i < WAYS; i++) begin
      if (fl.ret_en[i]) begin
        entries_next[tail + PTR_W'(ret_ofs[i])] = fl.ret_old_tag[i];
      end
    end
    if (reset) begin
      for (int j = 0; j < FL_DEPTH; j++) begin
        entries_next[j] = TAG_W'(ARCH_REGS + 32'(j));
      end
    end
  end

  always_ff @(posedge clock) begin
    entries <= entries_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      arch_head <= '0;
      tail      <= '0;
      count     <= CNT_W'(FL_DEPTH);
    end else begin
      tail      <= tail + PTR_W'(n_r);
      arch_head <= arch_head + PTR_W'(n_r);
      if (fl.squash) begin
        // Speculative grants are discarded by restoring head past this cycle's retirements.
        head  <= arch_head + PTR_W'(n_r);
        count <= CNT_W'(FL_DEPTH);
      end else begin
        head  <= head + PTR_W'(n_grant);
        count <= count - n_grant + n_r;
      end
    end
  end

`ifdef FREE_LIST_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fl_err_q <= 1'b0;
    end else if (over) begin
      fl_err_q <= 1'b1;
      $error("free_list: over-allocation, requested %0d with %0d free", n_a, count);
    end
  end
`endif

endmodule
